// File: rtl/imem_loader.sv
// Serial program loader: frames a byte stream into 16-bit instruction writes
// and holds the CPU in reset until the image checksum has been verified.
module imem_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_WAIT_HDR,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_RUN
  } state_e;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         remain_q, remain_d;
  logic [7:0]          xor_q, xor_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          cntHi_q, cntHi_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                err_q, err_d;

  logic        accept;
  logic [15:0] nWords;
  logic        oversize;

  assign accept   = byte_valid & byte_ready;
  assign nWords   = {cntHi_q, byte_in};
  assign oversize = {1'b0, nWords} > MAX_WORDS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_WAIT_HDR;
      addr_q   <= '0;
      remain_q <= '0;
      xor_q    <= '0;
      hi_q     <= '0;
      cntHi_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      xor_q    <= xor_d;
      hi_q     <= hi_d;
      cntHi_q  <= cntHi_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // reload outranks any byte offered in the same cycle
  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = S_WAIT_HDR;
    end else if (accept) begin
      case (state_q)
        S_WAIT_HDR: if (byte_in == HDR) state_d = S_CNT_HI;
        S_CNT_HI:   state_d = S_CNT_LO;
        S_CNT_LO: begin
          if (oversize)          state_d = S_WAIT_HDR;
          else if (nWords == '0) state_d = S_CHK;
          else                   state_d = S_DATA_HI;
        end
        S_DATA_HI:  state_d = S_DATA_LO;
        S_DATA_LO:  state_d = (remain_q == 16'd1) ? S_CHK : S_DATA_HI;
        S_CHK:      state_d = (byte_in == xor_q) ? S_RUN : S_WAIT_HDR;
        default:    state_d = state_q;
      endcase
    end
  end

  // The word counter counts down from N, so "reached N" is remain_q == 1 on the last lo byte
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    xor_d    = xor_q;
    hi_d     = hi_q;
    cntHi_d  = cntHi_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    if (reload) begin
      addr_d   = '0;
      remain_d = '0;
      xor_d    = '0;
    end else if (accept) begin
      case (state_q)
        S_WAIT_HDR: begin
          if (byte_in == HDR) begin
            err_d    = 1'b0;
            addr_d   = '0;
            remain_d = '0;
            xor_d    = '0;
          end
        end
        S_CNT_HI: cntHi_d = byte_in;
        S_CNT_LO: begin
          remain_d = nWords;
          if (oversize) err_d = 1'b1;
        end
        S_DATA_HI: begin
          hi_d  = byte_in;
          xor_d = xor_q ^ byte_in;
        end
        S_DATA_LO: begin
          we_d     = 1'b1;
          waddr_d  = addr_q;
          wdata_d  = {hi_q, byte_in};
          xor_d    = xor_q ^ byte_in;
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 16'd1;
        end
        S_CHK: if (byte_in != xor_q) err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_ready = (state_q != S_RUN);
    cpu_rst    = (state_q != S_RUN);
    done       = (state_q == S_RUN);
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=2): frames are driven byte by byte,
// expected memory writes go into a scoreboard queue and are matched as they appear.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 2;
  localparam logic [7:0]  HDR    = 8'hA5;

  logic              clk;
  logic              rst;
  logic [7:0]        byteIn;
  logic              byteValid;
  logic              byteReady;
  logic              reload;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [15:0]       imemWdata;
  logic              cpuRst;
  logic              done;
  logic              err;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [17:0] sbQ[$];
  logic [15:0] fw[4];
  logic [ADDR_W-1:0] addrModel;

  imem_loader #(.ADDR_W(ADDR_W), .HDR(HDR)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byteIn),
    .byte_valid (byteValid),
    .byte_ready (byteReady),
    .reload     (reload),
    .imem_we    (imemWe),
    .imem_addr  (imemAddr),
    .imem_wdata (imemWdata),
    .cpu_rst    (cpuRst),
    .done       (done),
    .err        (err)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every write strobe is matched against the oldest expected write in the scoreboard
  always @(negedge clk) begin
    if (imemWe === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_we", 32'(imemWe), 32'd0);
      end else begin
        logic [17:0] exp;
        exp = sbQ.pop_front();
        checkOutput("write", {14'd0, imemAddr, imemWdata}, {14'd0, exp});
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    byteIn    = b;
    byteValid = 1'b1;
    @(posedge clk);
    #1;
    byteValid = 1'b0;
  endtask

  task automatic doReload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  function automatic logic [7:0] computeChk(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) c = c ^ fw[i][15:8] ^ fw[i][7:0];
    return c;
  endfunction

  task automatic sendBody(input logic [15:0] n, input logic [7:0] chk);
    applyStimulus(n[15:8]);
    applyStimulus(n[7:0]);
    addrModel = '0;
    for (int i = 0; i < int'(n); i++) begin
      applyStimulus(fw[i][15:8]);
      sbQ.push_back({addrModel, fw[i]});
      applyStimulus(fw[i][7:0]);
      addrModel = addrModel + 1'b1;
    end
    applyStimulus(chk);
  endtask

  task automatic checkBooted(input string tag);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_cpu_rst"}, 32'(cpuRst), 32'd0);
    checkOutput({tag, "_ready"}, 32'(byteReady), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Main scenario sequence; all waits are fixed clock counts so the run always ends
  initial begin
    rst       = 1'b0;
    byteIn    = 8'h00;
    byteValid = 1'b0;
    reload    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cpu_rst", 32'(cpuRst), 32'd1);
    checkOutput("rst_we", 32'(imemWe), 32'd0);
    checkOutput("rst_addr", 32'(imemAddr), 32'd0);
    checkOutput("rst_wdata", 32'(imemWdata), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_ready", 32'(byteReady), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Normal load: two words, checksum 12^34^AB^CD = 40
    fw[0] = 16'h1234;
    fw[1] = 16'hABCD;
    applyStimulus(HDR);
    sendBody(16'd2, computeChk(2));
    checkOutput("normal_chk_value", 32'(computeChk(2)), 32'h40);
    @(negedge clk);
    checkBooted("normal");
    checkOutput("normal_drain", sbQ.size(), 32'd0);

    // Reload from RUN returns to load mode on the next cycle
    doReload();
    checkOutput("reload_cpu_rst", 32'(cpuRst), 32'd1);
    checkOutput("reload_done", 32'(done), 32'd0);
    checkOutput("reload_ready", 32'(byteReady), 32'd1);

    // Bad checksum: writes still happen, err set, CPU held
    applyStimulus(HDR);
    sendBody(16'd2, 8'h00);
    @(negedge clk);
    checkOutput("badchk_err", 32'(err), 32'd1);
    checkOutput("badchk_cpu_rst", 32'(cpuRst), 32'd1);
    checkOutput("badchk_done", 32'(done), 32'd0);
    checkOutput("badchk_drain", sbQ.size(), 32'd0);
    fw[0] = 16'h0F0F;
    fw[1] = 16'h5A3C;
    applyStimulus(HDR);
    checkOutput("hdr_clears_err", 32'(err), 32'd0);
    sendBody(16'd2, computeChk(2));
    @(negedge clk);
    checkBooted("after_bad");

    // Garbage before header, then an empty image
    doReload();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkOutput("garbage_ready", 32'(byteReady), 32'd1);
    applyStimulus(HDR);
    sendBody(16'd0, 8'h00);
    @(negedge clk);
    checkBooted("empty");

    // Oversize count with ADDR_W=2: N=5 rejected, N=4 fills 0..3 and wraps without a write
    doReload();
    applyStimulus(HDR);
    applyStimulus(8'h00);
    applyStimulus(8'h05);
    checkOutput("oversize_err", 32'(err), 32'd1);
    checkOutput("oversize_ready", 32'(byteReady), 32'd1);
    checkOutput("oversize_cpu_rst", 32'(cpuRst), 32'd1);
    fw[0] = 16'h1111;
    fw[1] = 16'h2222;
    fw[2] = 16'h3344;
    fw[3] = 16'hF00D;
    applyStimulus(HDR);
    sendBody(16'd4, computeChk(4));
    @(negedge clk);
    checkBooted("full");
    checkOutput("full_drain", sbQ.size(), 32'd0);

    // Reload mid-data with a lo byte offered in the same cycle: no write
    doReload();
    fw[0] = 16'hC001;
    applyStimulus(HDR);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(fw[0][15:8]);
    sbQ.push_back({2'd0, fw[0]});
    applyStimulus(fw[0][7:0]);
    applyStimulus(8'h77);
    byteIn    = 8'h66;
    byteValid = 1'b1;
    reload    = 1'b1;
    @(posedge clk);
    #1;
    byteValid = 1'b0;
    reload    = 1'b0;
    checkOutput("midreload_ready", 32'(byteReady), 32'd1);
    checkOutput("midreload_cpu_rst", 32'(cpuRst), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midreload_drain", sbQ.size(), 32'd0);
    fw[0] = 16'hBEEF;
    applyStimulus(HDR);
    sendBody(16'd1, computeChk(1));
    @(negedge clk);
    checkBooted("post_reload");

    // Asynchronous reset between hi and lo bytes
    doReload();
    fw[0] = 16'h1357;
    fw[1] = 16'h2468;
    applyStimulus(HDR);
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    addrModel = '0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(fw[i][15:8]);
      sbQ.push_back({addrModel, fw[i]});
      applyStimulus(fw[i][7:0]);
      addrModel = addrModel + 1'b1;
    end
    applyStimulus(8'h9A);
    byteIn    = 8'hBC;
    byteValid = 1'b1;
    rst       = 1'b0;
    #1;
    checkOutput("arst_cpu_rst", 32'(cpuRst), 32'd1);
    checkOutput("arst_we", 32'(imemWe), 32'd0);
    checkOutput("arst_addr", 32'(imemAddr), 32'd0);
    checkOutput("arst_wdata", 32'(imemWdata), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_ready", 32'(byteReady), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    byteValid = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("arst_no_write", 32'(imemWe), 32'd0);
    checkOutput("arst_drain", sbQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
